// File: rtl/axis_to_video_pkg.sv
// rtl/axis_to_video_pkg.sv - shared raster constants, FSM encodings and sync window helper
package axis_to_video_pkg;

  localparam int CNT_BITS = 12;

  localparam int DEF_H_DISP = 960;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 32;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 544;
  localparam int DEF_V_FP   = 3;
  localparam int DEF_V_SYNC = 5;
  localparam int DEF_V_BP   = 20;

  localparam logic [1:0] ST_SEEK   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic in_window(input logic [CNT_BITS-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO; head word is visible on rdata_o while not empty
module sync_fifo_fwft #(
  parameter int WIDTH     = 10,
  parameter int ADDR_BITS = 5
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q;
  logic [ADDR_BITS-1:0] rd_ptr_q;
  logic [ADDR_BITS:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = count_q[ADDR_BITS];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/axis_to_video.sv
// rtl/axis_to_video.sv - AXI4-Stream pixels (tuser=SOF) to raster video with a free-running timing generator
module axis_to_video
  import axis_to_video_pkg::*;
#(
  parameter int   DATA_BITS = 8,
  parameter int   ADDR_BITS = 5,
  parameter int   H_DISP    = DEF_H_DISP,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_DISP    = DEF_V_DISP,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 vid_ce,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 vid_vsync,
  output logic                 vid_hsync,
  output logic                 vid_active_video,
  output logic [DATA_BITS-1:0] vid_data,
  output logic                 locked,
  output logic                 underflow,
  output logic                 sync_err
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  logic [CNT_BITS-1:0]  h_cnt_q, h_cnt_d;
  logic [CNT_BITS-1:0]  v_cnt_q, v_cnt_d;
  logic [1:0]           state_q, state_d;
  logic                 hsync_q, vsync_q, active_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 underflow_q, underflow_d;
  logic                 sync_err_q, sync_err_d;

  logic [DATA_BITS+1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic                 head_tuser;
  logic                 unused_head_tlast;
  logic [DATA_BITS-1:0] head_data;
  logic                 pix_active, at_origin, hsync_on, vsync_on;

  sync_fifo_fwft #(
    .WIDTH     (DATA_BITS + 2),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk_i    (aclk),
    .resetn_i (aresetn),
    .push_i   (s_axis_tvalid),
    .wdata_i  ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign head_tuser        = fifo_rdata[DATA_BITS+1];
  assign unused_head_tlast = fifo_rdata[DATA_BITS];
  assign head_data         = fifo_rdata[DATA_BITS-1:0];

  assign pix_active = (int'(h_cnt_q) < H_DISP) && (int'(v_cnt_q) < V_DISP);
  assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hsync_on   = in_window(h_cnt_q, H_DISP + H_FP, H_SYNC);
  assign vsync_on   = in_window(v_cnt_q, V_DISP + V_FP, V_SYNC);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vid_ce) begin
      if (int'(h_cnt_q) == H_TOTAL - 1) begin
        h_cnt_d = '0;
        if (int'(v_cnt_q) == V_TOTAL - 1) v_cnt_d = '0;
        else                              v_cnt_d = v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // The FSM only acts on pixel ticks; a SOF beat out of place is held so it can start the next frame.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    data_d      = '0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    if (vid_ce) begin
      case (state_q)
        ST_SEEK: begin
          if (!fifo_empty) begin
            if (head_tuser) state_d  = ST_WAIT;
            else            fifo_pop = 1'b1;
          end
        end
        ST_WAIT: begin
          if (pix_active && at_origin && !fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = head_data;
            state_d  = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (pix_active) begin
            if (fifo_empty) begin
              underflow_d = 1'b1;
              state_d     = ST_SEEK;
            end else if (head_tuser && !at_origin) begin
              sync_err_d = 1'b1;
              state_d    = ST_WAIT;
            end else begin
              fifo_pop = 1'b1;
              data_d   = head_data;
            end
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      state_q     <= ST_SEEK;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      active_q    <= 1'b0;
      data_q      <= '0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      state_q     <= state_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
      if (vid_ce) begin
        hsync_q  <= hsync_on ? SYNC_POL : ~SYNC_POL;
        vsync_q  <= vsync_on ? SYNC_POL : ~SYNC_POL;
        active_q <= pix_active;
        data_q   <= data_d;
      end
    end
  end

  assign s_axis_tready    = !fifo_full;
  assign vid_hsync        = hsync_q;
  assign vid_vsync        = vsync_q;
  assign vid_active_video = active_q;
  assign vid_data         = data_q;
  assign locked           = (state_q == ST_LOCKED);
  assign underflow        = underflow_q;
  assign sync_err         = sync_err_q;

endmodule

// File: tb/tb_axis_to_video.sv
// tb/tb_axis_to_video.sv - directed scenarios on a 14x7 raster (8x4 active)
module tb_axis_to_video;

  localparam int DW  = 8;
  localparam int CAP = 400;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          vid_ce = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          vid_vsync, vid_hsync, vid_active_video;
  logic [DW-1:0] vid_data;
  logic          locked, underflow, sync_err;

  int errors = 0;
  int checks = 0;

  logic          cap_act [CAP];
  logic          cap_hs  [CAP];
  logic          cap_vs  [CAP];
  logic          cap_lk  [CAP];
  logic          cap_uf  [CAP];
  logic          cap_se  [CAP];
  logic [DW-1:0] cap_dat [CAP];

  axis_to_video #(
    .DATA_BITS (DW), .ADDR_BITS (5),
    .H_DISP (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_DISP (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b1)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .vid_ce           (vid_ce),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .vid_vsync        (vid_vsync),
    .vid_hsync        (vid_hsync),
    .vid_active_video (vid_active_video),
    .vid_data         (vid_data),
    .locked           (locked),
    .underflow        (underflow),
    .sync_err         (sync_err)
  );

  always #5 aclk = ~aclk;

  // Sample n reflects the outputs after the n-th rising edge following reset release (edge 0 = pixel (0,0)).
  function automatic int pix_n(input int frame, input int p);
    return frame * 98 + (p / 8) * 14 + (p % 8);
  endfunction

  task automatic do_reset();
    vid_ce = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic capture(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge aclk);
      cap_act[i] = vid_active_video;
      cap_hs[i]  = vid_hsync;
      cap_vs[i]  = vid_vsync;
      cap_lk[i]  = locked;
      cap_uf[i]  = underflow;
      cap_se[i]  = sync_err;
      cap_dat[i] = vid_data;
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int waited;
    waited = 0;
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && waited < 1000) begin
      @(posedge aclk); #1;
      waited++;
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout got tready=%b exp=1", s_axis_tready);
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0;
  endtask

  task automatic push_frame(input int nbeats, input int base, input int sof2);
    for (int i = 0; i < nbeats; i++)
      push_beat(8'(base + i), (i == 0) || (i == sof2), (i % 8) == 7);
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({vid_hsync, vid_vsync, vid_active_video, locked, underflow, sync_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got hs,vs,act,lk,uf,se=%b exp=000000",
               {vid_hsync, vid_vsync, vid_active_video, locked, underflow, sync_err});
    end
    checks++;
    if (vid_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got=%0h exp=0", vid_data);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got=%b exp=1", s_axis_tready);
    end
    checks++;
    if ({vid_active_video, vid_hsync, vid_vsync, vid_data} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL reset_origin got act,hs,vs,data=%b%b%b,%0h exp=100,0",
               vid_active_video, vid_hsync, vid_vsync, vid_data);
    end
  endtask

  task automatic test_lock();
    int h, v;
    logic ea, ehs, evs, elk;
    logic [DW-1:0] ed;
    do_reset();
    fork
      capture(200);
      begin
        push_frame(32, 0, -1);
        checks++;
        if ({s_axis_tready, locked} !== 2'b00) begin
          errors++;
          $display("FAIL lock_full_wait got tready,locked=%b%b exp=00", s_axis_tready, locked);
        end
      end
    join
    for (int n = 0; n < 196; n++) begin
      h = n % 14;
      v = (n / 14) % 7;
      ea  = (h < 8) && (v < 4);
      ehs = (h >= 10) && (h < 12);
      evs = (v == 5);
      elk = (n >= 98);
      ed  = (elk && ea) ? 8'(v * 8 + h) : 8'h00;
      checks++;
      if ({cap_act[n], cap_hs[n], cap_vs[n], cap_lk[n]} !== {ea, ehs, evs, elk}) begin
        errors++;
        $display("FAIL lock_timing n=%0d got act,hs,vs,lk=%b%b%b%b exp=%b%b%b%b",
                 n, cap_act[n], cap_hs[n], cap_vs[n], cap_lk[n], ea, ehs, evs, elk);
      end
      checks++;
      if (cap_dat[n] !== ed) begin
        errors++;
        $display("FAIL lock_data n=%0d got=%0h exp=%0h", n, cap_dat[n], ed);
      end
    end
  endtask

  task automatic test_junk();
    int n;
    do_reset();
    fork
      capture(200);
      begin
        for (int i = 0; i < 5; i++) push_beat(8'(8'hA0 + i), 1'b0, 1'b0);
        push_frame(32, 0, -1);
      end
    join
    for (int p = 0; p < 32; p++) begin
      n = pix_n(1, p);
      checks++;
      if ({cap_dat[n], cap_lk[n]} !== {8'(p), 1'b1}) begin
        errors++;
        $display("FAIL junk_pixel p=%0d got data=%0h lk=%b exp data=%0h lk=1", p, cap_dat[n], cap_lk[n], p);
      end
    end
    checks++;
    if (cap_lk[97] !== 1'b0) begin
      errors++;
      $display("FAIL junk_prelock got=%b exp=0", cap_lk[97]);
    end
  endtask

  task automatic test_underflow();
    int n;
    do_reset();
    fork
      capture(260);
      begin
        push_frame(20, 0, -1);
        repeat (120) @(posedge aclk);
        #1;
        push_frame(32, 100, -1);
      end
    join
    for (int p = 0; p < 20; p++) begin
      n = pix_n(1, p);
      checks++;
      if (cap_dat[n] !== 8'(p)) begin
        errors++;
        $display("FAIL uf_pixel p=%0d got=%0h exp=%0h", p, cap_dat[n], p);
      end
    end
    n = pix_n(1, 20);
    checks++;
    if ({cap_dat[n], cap_uf[n], cap_lk[n], cap_act[n]} !== {8'h00, 3'b101}) begin
      errors++;
      $display("FAIL uf_pulse got data=%0h uf,lk,act=%b%b%b exp data=0 uf,lk,act=101",
               cap_dat[n], cap_uf[n], cap_lk[n], cap_act[n]);
    end
    checks++;
    if ({cap_uf[n-1], cap_lk[n-1], cap_uf[n+1], cap_lk[n+1], cap_dat[n+1]} !== {4'b0100, 8'h00}) begin
      errors++;
      $display("FAIL uf_edges got uf,lk before=%b%b after=%b%b data after=%0h exp 01 00 0",
               cap_uf[n-1], cap_lk[n-1], cap_uf[n+1], cap_lk[n+1], cap_dat[n+1]);
    end
    for (int p = 0; p < 32; p++) begin
      n = pix_n(2, p);
      checks++;
      if ({cap_dat[n], cap_lk[n]} !== {8'(100 + p), 1'b1}) begin
        errors++;
        $display("FAIL uf_relock p=%0d got data=%0d lk=%b exp data=%0d lk=1", p, cap_dat[n], cap_lk[n], 100 + p);
      end
    end
  endtask

  task automatic test_misalign();
    int n;
    logic [DW-1:0] ed;
    do_reset();
    fork
      capture(240);
      push_frame(32, 0, 12);
    join
    for (int p = 0; p < 32; p++) begin
      n  = pix_n(1, p);
      ed = (p < 12) ? 8'(p) : 8'h00;
      checks++;
      if (cap_dat[n] !== ed) begin
        errors++;
        $display("FAIL mis_pixel p=%0d got=%0h exp=%0h", p, cap_dat[n], ed);
      end
    end
    n = pix_n(1, 12);
    checks++;
    if ({cap_se[n-1], cap_lk[n-1], cap_se[n], cap_lk[n], cap_se[n+1]} !== 5'b01100) begin
      errors++;
      $display("FAIL mis_pulse got se,lk before=%b%b at=%b%b se after=%b exp 01 10 0",
               cap_se[n-1], cap_lk[n-1], cap_se[n], cap_lk[n], cap_se[n+1]);
    end
    for (int p = 0; p < 20; p++) begin
      n = pix_n(2, p);
      checks++;
      if ({cap_dat[n], cap_lk[n]} !== {8'(12 + p), 1'b1}) begin
        errors++;
        $display("FAIL mis_next p=%0d got data=%0h lk=%b exp data=%0h lk=1", p, cap_dat[n], cap_lk[n], 12 + p);
      end
    end
    n = pix_n(2, 20);
    checks++;
    if (cap_uf[n] !== 1'b1) begin
      errors++;
      $display("FAIL mis_tail_uf got=%b exp=1", cap_uf[n]);
    end
  endtask

  task automatic test_ce_backpressure();
    int t;
    do_reset();
    fork
      capture(240);
      for (int i = 0; i < 240; i++) begin
        vid_ce = ~vid_ce;
        @(posedge aclk); #1;
      end
      begin
        push_frame(32, 0, -1);
        checks++;
        if ({s_axis_tready, locked} !== 2'b00) begin
          errors++;
          $display("FAIL ce_full got tready,locked=%b%b exp=00", s_axis_tready, locked);
        end
      end
    join
    vid_ce = 1'b1;
    checks++;
    if ({cap_hs[19], cap_hs[20], cap_hs[21], cap_hs[23], cap_hs[24]} !== 5'b01110) begin
      errors++;
      $display("FAIL ce_hsync got n19..24=%b%b%b%b%b exp=01110",
               cap_hs[19], cap_hs[20], cap_hs[21], cap_hs[23], cap_hs[24]);
    end
    checks++;
    if ({cap_vs[139], cap_vs[140], cap_vs[141]} !== 3'b011) begin
      errors++;
      $display("FAIL ce_vsync got n139..141=%b%b%b exp=011", cap_vs[139], cap_vs[140], cap_vs[141]);
    end
    checks++;
    if ({cap_act[0], cap_act[15], cap_act[16]} !== 3'b110) begin
      errors++;
      $display("FAIL ce_active got n0,15,16=%b%b%b exp=110", cap_act[0], cap_act[15], cap_act[16]);
    end
    checks++;
    if ({cap_lk[195], cap_lk[196]} !== 2'b01) begin
      errors++;
      $display("FAIL ce_lock got n195,196=%b%b exp=01", cap_lk[195], cap_lk[196]);
    end
    for (int p = 0; p < 16; p++) begin
      t = pix_n(1, p);
      checks++;
      if ({cap_dat[2*t], cap_dat[2*t+1]} !== {8'(p), 8'(p)}) begin
        errors++;
        $display("FAIL ce_pixel p=%0d got=%0h,%0h exp=%0h,%0h", p, cap_dat[2*t], cap_dat[2*t+1], p, p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_reset();
    test_junk();
    test_underflow();
    test_misalign();
    test_ce_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
